// File: rtl/mem_store_serializer.sv
// rtl/mem_store_serializer.sv - byte-serial SB/SH/SW store engine for a byte-wide data memory
// Optional build macro: STORE_MISALIGN_TRAP_EN (reject misaligned half/word instead of force-aligning)
module mem_store_serializer #(
    parameter int BITS_SIZE      = 32,
    parameter int BYTE_BITS_SIZE = 8,
    parameter int BITS_ADDR      = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_store_valid,
    input  logic [1:0]                i_store_size,
    input  logic [BITS_SIZE-1:0]      i_store_addr,
    input  logic [BITS_SIZE-1:0]      i_store_data,
    output logic                      o_stall,
    output logic                      o_mem_we,
    output logic [BITS_ADDR-1:0]      o_mem_addr,
    output logic [BYTE_BITS_SIZE-1:0] o_mem_wdata,
    output logic                      o_done,
    output logic                      o_misaligned
);

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_t;

    state_t               state;
    logic [1:0]           idx;
    logic [1:0]           lat_last;
    logic [BITS_ADDR-1:0] lat_addr;
    logic [BITS_SIZE-1:0] lat_data;

    logic [1:0]           req_last;
    logic [BITS_ADDR-1:0] req_addr;
    logic                 req_misaligned;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^i_store_addr[BITS_SIZE-1:BITS_ADDR];

    // Index of the final byte doubles as the alignment mask (half: 01, word: 11).
    always_comb begin
        req_last = 2'd3;
        case (i_store_size)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign req_misaligned = (i_store_addr[1:0] & req_last) != 2'b00;
    assign req_addr       = i_store_addr[BITS_ADDR-1:0];
`else
    assign req_misaligned = 1'b0;
    assign req_addr       = i_store_addr[BITS_ADDR-1:0] & ~{{(BITS_ADDR-2){1'b0}}, req_last};
`endif

    always_comb begin
        o_stall      = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_done       = 1'b0;
        o_misaligned = 1'b0;
        if (!i_reset_n) begin
            o_stall = 1'b0;
        end else if (state == ST_WRITE) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = lat_addr + BITS_ADDR'(idx);
            o_mem_wdata = BYTE_BITS_SIZE'(lat_data >> (32'(idx) * BYTE_BITS_SIZE));
            o_done      = (idx == lat_last);
            o_stall     = (idx != lat_last);
        end else if (i_store_valid) begin
            if (req_misaligned) begin
                o_misaligned = 1'b1;
            end else begin
                // Byte 0 goes out in the request cycle itself.
                o_mem_we    = 1'b1;
                o_mem_addr  = req_addr;
                o_mem_wdata = i_store_data[BYTE_BITS_SIZE-1:0];
                o_done      = (req_last == 2'd0);
                o_stall     = (req_last != 2'd0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            lat_last <= 2'd0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_store_valid && !req_misaligned && req_last != 2'd0) begin
                        state    <= ST_WRITE;
                        idx      <= 2'd1;
                        lat_last <= req_last;
                        lat_addr <= req_addr;
                        lat_data <= i_store_data;
                    end
                end
                ST_WRITE: begin
                    if (idx == lat_last) begin
                        state <= ST_IDLE;
                        idx   <= 2'd0;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_serializer.sv
// tb/tb_mem_store_serializer.sv - self-checking bench for mem_store_serializer
module tb_mem_store_serializer;

    logic        clk;
    logic        rst_n;
    logic        store_valid;
    logic [1:0]  store_size;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        stall;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        done;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    mem_store_serializer #(
        .BITS_SIZE     (32),
        .BYTE_BITS_SIZE(8),
        .BITS_ADDR     (8)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_store_valid(store_valid),
        .i_store_size (store_size),
        .i_store_addr (store_addr),
        .i_store_data (store_data),
        .o_stall      (stall),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_done       (done),
        .o_misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {we, addr, wdata, stall, done, misaligned}
    function automatic logic [19:0] pack(input logic we, input logic [7:0] a, input logic [7:0] d,
                                         input logic st, input logic dn, input logic mis);
        return {we, a, d, st, dn, mis};
    endfunction

    localparam logic [19:0] FULL_MASK = 20'hFFFFF;
    localparam logic [19:0] CTRL_MASK = 20'h80007;

    function automatic void compare(input string name, input logic [19:0] exp, input logic [19:0] mask);
        logic [19:0] got;
        got = pack(mem_we, mem_addr, mem_wdata, stall, done, misaligned);
        checks++;
        if ((got & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got we/addr/wdata/stall/done/mis=%h required=%h", name, got & mask, exp & mask);
        end
    endfunction

    task automatic check_cycle(input string name, input logic [19:0] exp, input logic [19:0] mask);
        @(negedge clk);
        compare(name, exp, mask);
        @(posedge clk);
        #1;
    endtask

    // Drives one request; during the stalled cycles the inputs are replaced by junk.
    task automatic run_request(input string name, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] data, input logic exp_mis, input int exp_n,
                               input logic [7:0] exp_base, input logic [31:0] exp_bytes,
                               input logic random_junk);
        store_valid = 1'b1;
        store_size  = size;
        store_addr  = addr;
        store_data  = data;
        if (exp_mis) begin
            check_cycle({name, "_trap"}, pack(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1), CTRL_MASK);
        end else begin
            for (int k = 0; k < exp_n; k++) begin
                if (k > 0) begin
                    if (random_junk) begin
                        store_valid = 1'($urandom_range(0, 1));
                        store_size  = 2'($urandom_range(0, 3));
                        store_addr  = $urandom;
                        store_data  = $urandom;
                    end else begin
                        store_valid = 1'b1;
                        store_size  = 2'b00;
                        store_addr  = 32'h70;
                        store_data  = 32'hFF;
                    end
                end
                check_cycle($sformatf("%s_b%0d", name, k),
                            pack(1'b1, exp_base + 8'(k), exp_bytes[8*k +: 8],
                                 k < exp_n - 1, k == exp_n - 1, 1'b0), FULL_MASK);
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_mis;
        int          exp_n;
        logic [7:0]  exp_base;
        logic [31:0] exp_bytes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        logic [31:0] r_data;
        int          n;
        logic        r_mis;
        logic [7:0]  r_base;

        vecs[0] = '{"sb_10", 2'b00, 32'h10, 32'hAABBCCDD, 1'b0, 1, 8'h10, 32'h000000DD};
        vecs[1] = '{"sw_20", 2'b11, 32'h20, 32'h11223344, 1'b0, 4, 8'h20, 32'h11223344};
`ifdef STORE_MISALIGN_TRAP_EN
        vecs[2] = '{"sh_31", 2'b01, 32'h31, 32'h0000BEEF, 1'b1, 0, 8'h00, 32'h00000000};
`else
        vecs[2] = '{"sh_31", 2'b01, 32'h31, 32'h0000BEEF, 1'b0, 2, 8'h30, 32'h0000BEEF};
`endif
        vecs[3] = '{"sh_40", 2'b01, 32'h40, 32'h00001234, 1'b0, 2, 8'h40, 32'h00001234};
        vecs[4] = '{"sb_50", 2'b00, 32'h50, 32'h00000099, 1'b0, 1, 8'h50, 32'h00000099};
        vecs[5] = '{"sw_60", 2'b10, 32'h60, 32'hCAFEF00D, 1'b0, 4, 8'h60, 32'hCAFEF00D};

        rst_n       = 1'b0;
        store_valid = 1'b1;
        store_size  = 2'b11;
        store_addr  = 32'h44;
        store_data  = 32'h12345678;
        @(negedge clk);
        compare("reset_outputs", 20'h0, FULL_MASK);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        store_valid = 1'b0;
        check_cycle("idle_after_reset", 20'h0, FULL_MASK);

        for (int i = 0; i < 6; i++)
            run_request(vecs[i].name, vecs[i].size, vecs[i].addr, vecs[i].data, vecs[i].exp_mis,
                        vecs[i].exp_n, vecs[i].exp_base, vecs[i].exp_bytes, 1'b0);
        store_valid = 1'b0;
        check_cycle("idle_after_table", 20'h0, FULL_MASK);

        // Reset in the middle of a word store: the remaining two bytes must never appear.
        store_valid = 1'b1;
        store_size  = 2'b11;
        store_addr  = 32'h80;
        store_data  = 32'h87654321;
        check_cycle("rst_sw_b0", pack(1'b1, 8'h80, 8'h21, 1'b1, 1'b0, 1'b0), FULL_MASK);
        check_cycle("rst_sw_b1", pack(1'b1, 8'h81, 8'h43, 1'b1, 1'b0, 1'b0), FULL_MASK);
        rst_n = 1'b0;
        #1;
        compare("rst_immediate", 20'h0, FULL_MASK);
        check_cycle("rst_held", 20'h0, FULL_MASK);
        rst_n       = 1'b1;
        store_valid = 1'b0;
        check_cycle("rst_no_resume", 20'h0, FULL_MASK);
        run_request("sb_90", 2'b00, 32'h90, 32'h0000005A, 1'b0, 1, 8'h90, 32'h0000005A, 1'b0);
        store_valid = 1'b0;
        check_cycle("idle_after_sb_90", 20'h0, FULL_MASK);

        // Random traffic against a plain-arithmetic store model.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                store_valid = 1'b0;
                store_size  = 2'($urandom_range(0, 3));
                store_addr  = $urandom;
                store_data  = $urandom;
                check_cycle("rand_idle", 20'h0, FULL_MASK);
            end else begin
                r_size = 2'($urandom_range(0, 3));
                r_addr = $urandom;
                r_data = $urandom;
                n      = (r_size == 2'b00) ? 1 : (r_size == 2'b01) ? 2 : 4;
`ifdef STORE_MISALIGN_TRAP_EN
                r_mis  = (r_addr % n) != 0;
`else
                r_mis  = 1'b0;
`endif
                r_base = 8'((r_addr % 256) - ((r_addr % 256) % n));
                run_request("rand", r_size, r_addr, r_data, r_mis, n, r_base, r_data, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
